// File: rtl/reset_sequencer_if.sv
// ============================================================================
// Module   : reset_sequencer_if
// Brief    : Reset sources in, per-domain resets and status out, for reset_sequencer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface reset_sequencer_if #(
    parameter int NUM_DOMAINS = 4
);
    logic                   btn_n;
    logic                   pll_lock;
    logic                   sw_reset_req;
    logic [NUM_DOMAINS-1:0] domain_resetn;
    logic                   reset_active;
    logic [1:0]             reset_cause;
    logic [7:0]             reset_count;

    // master: the SoC side raising reset sources and observing status
    modport master (
        output btn_n, pll_lock, sw_reset_req,
        input  domain_resetn, reset_active, reset_cause, reset_count
    );

    // slave: the sequencer itself
    modport slave (
        input  btn_n, pll_lock, sw_reset_req,
        output domain_resetn, reset_active, reset_cause, reset_count
    );
endinterface

`default_nettype wire

// File: rtl/reset_sequencer.sv
// ============================================================================
// Module   : reset_sequencer
// Brief    : Merges four reset sources and releases NUM_DOMAINS resets in order.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module reset_sequencer #(
    parameter int NUM_DOMAINS     = 4,
    parameter int STRETCH_CYCLES  = 15,
    parameter int RELEASE_GAP     = 8,
    parameter int DEBOUNCE_CYCLES = 65535,
    parameter int SYNC_STAGES     = 2
) (
    input  wire logic         clkout,
    input  wire logic         ext_reset,
    reset_sequencer_if.slave  bus
);

    localparam int IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam int CNT_MAX = (STRETCH_CYCLES > RELEASE_GAP) ? STRETCH_CYCLES : RELEASE_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CNT_W-1:0] c_STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_GAP_LAST     = CNT_W'(RELEASE_GAP - 1);
    localparam logic [DB_W-1:0]  c_DB_LAST      = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [IDX_W:0]   c_LAST_IDX     = (IDX_W + 1)'(NUM_DOMAINS - 1);

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_STRETCH = 2'd1,
        S_RELEASE = 2'd2,
        S_RUN     = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_rst_sync;
    logic [SYNC_STAGES-1:0] r_pll_sync;
    logic [SYNC_STAGES-1:0] r_btn_sync;
    logic [DB_W-1:0]        r_db_cnt;
    logic                   r_btn_db;
    logic                   r_btn_db_d;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [IDX_W-1:0]       r_idx;
    logic [NUM_DOMAINS-1:0] r_domain_resetn;
    logic                   r_reset_active;
    logic [1:0]             r_reset_cause;
    logic [7:0]             r_reset_count;

    logic                   w_rst_n;
    logic                   w_pll_s;
    logic                   w_btn_s;
    logic                   w_pll_ev;
    logic                   w_btn_ev;
    logic                   w_sw_ev;
    logic                   w_any_ev;
    logic [1:0]             w_ev_cause;
    logic [IDX_W:0]         w_next_idx;

    // Assertion reaches the core immediately; only the release is synchronised.
    always_ff @(posedge clkout or negedge ext_reset) begin
        if (!ext_reset) begin
            r_rst_sync <= '0;
        end else begin
            r_rst_sync <= {r_rst_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[SYNC_STAGES-1];

    always_ff @(posedge clkout or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_pll_sync <= '0;
            r_btn_sync <= '1;
        end else begin
            r_pll_sync <= {r_pll_sync[SYNC_STAGES-2:0], bus.pll_lock};
            r_btn_sync <= {r_btn_sync[SYNC_STAGES-2:0], bus.btn_n};
        end
    end

    assign w_pll_s = r_pll_sync[SYNC_STAGES-1];
    assign w_btn_s = r_btn_sync[SYNC_STAGES-1];

    // The debounced level flips only after an unbroken run of differing samples.
    always_ff @(posedge clkout or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_db_cnt   <= '0;
            r_btn_db   <= 1'b1;
            r_btn_db_d <= 1'b1;
        end else begin
            r_btn_db_d <= r_btn_db;
            if (w_btn_s == r_btn_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_DB_LAST) begin
                r_btn_db <= w_btn_s;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    assign w_pll_ev   = ~w_pll_s;
    assign w_btn_ev   = r_btn_db_d & ~r_btn_db;
    assign w_sw_ev    = bus.sw_reset_req;
    assign w_any_ev   = w_pll_ev | w_btn_ev | w_sw_ev;
    assign w_next_idx = {1'b0, r_idx} + 1'b1;

    always_comb begin
        w_ev_cause = 2'b11;
        if (w_pll_ev) begin
            w_ev_cause = 2'b10;
        end else if (w_btn_ev) begin
            w_ev_cause = 2'b01;
        end
    end

    always_ff @(posedge clkout or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state         <= S_HOLD;
            r_cnt           <= '0;
            r_idx           <= '0;
            r_domain_resetn <= '0;
            r_reset_active  <= 1'b1;
            r_reset_cause   <= 2'b00;
            r_reset_count   <= 8'd0;
        end else if (r_state == S_HOLD) begin
            // A software request while already holding only relabels the cause.
            if (w_sw_ev) begin
                r_reset_cause <= 2'b11;
            end
            if (w_pll_s && r_btn_db) begin
                r_state <= S_STRETCH;
                r_cnt   <= '0;
            end
        end else if (w_any_ev) begin
            r_state         <= S_HOLD;
            r_domain_resetn <= '0;
            r_reset_active  <= 1'b1;
            r_reset_cause   <= w_ev_cause;
            if (r_reset_count != 8'hFF) begin
                r_reset_count <= r_reset_count + 8'd1;
            end
        end else begin
            case (r_state)
                S_STRETCH: begin
                    if (r_cnt == c_STRETCH_LAST) begin
                        r_cnt           <= '0;
                        r_idx           <= '0;
                        r_domain_resetn <= r_domain_resetn | NUM_DOMAINS'(1);
                        if (NUM_DOMAINS == 1) begin
                            r_state        <= S_RUN;
                            r_reset_active <= 1'b0;
                        end else begin
                            r_state <= S_RELEASE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (r_cnt == c_GAP_LAST) begin
                        r_cnt           <= '0;
                        r_idx           <= w_next_idx[IDX_W-1:0];
                        r_domain_resetn <= r_domain_resetn | (NUM_DOMAINS'(1) << w_next_idx);
                        if (w_next_idx == c_LAST_IDX) begin
                            r_state        <= S_RUN;
                            r_reset_active <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.domain_resetn = r_domain_resetn;
    assign bus.reset_active  = r_reset_active;
    assign bus.reset_cause   = r_reset_cause;
    assign bus.reset_count   = r_reset_count;

endmodule

`default_nettype wire
